pri_enc_seq: RTL and testbench
==============================

// Module: pri_enc_seq
// PURPOSE
//  Parametrised sequential priority encoder; successor to the 8-to-3 combinational encoder.
//  On Start, latches an N-bit request vector and emits, one per accepted handshake, the
//  index of every set bit in priority order (highest index first), then pulses Done.
//  Sits between a request/flag register and a consumer that services one request at a time.
// PARAMETERS
//  N  8             number of request inputs (N >= 2)
//  W  $clog2(N)     index width of Y (derived; not overridden)
// PORTS
//  CLK    in   1  single clock, rising edge
//  RST_n  in   1  asynchronous active-low reset
//  EN     in   1  active-low enable (0 = run, 1 = hold), as in the combinational encoder
//  Start  in   1  load In and begin a scan (sampled only in IDLE with EN=0)
//  In     in   N  request vector
//  Ready  in   1  consumer accepts Y this cycle when Valid=1
//  Y      out  W  index of current highest-priority pending bit (registered)
//  Valid  out  1  Y is meaningful
//  Busy   out  1  scan in progress (SCAN state)
//  None   out  1  latched vector was all-zero; held until next Start
//  Done   out  1  one-cycle pulse: scan complete
// BEHAVIOUR
//  Reset (RST_n=0, async): state=IDLE, pend=0, Y=0, Valid=0, Busy=0, None=0, Done=0.
//  FSM states: IDLE, SCAN, FIN.
//  IDLE: Start=1 & EN=0 at edge k -> pend<=In, None<=0.
//   If In!=0 -> SCAN. Valid=1 and Y=top index are visible after edge k (1-cycle latency).
//   If In==0 -> FIN, None<=1, Valid stays 0.
//  SCAN: Valid=1, Y=index of highest set bit in pend.
//   Valid&Ready&EN=0 at an edge -> clear that bit in pend; Y updates to the next index at the same edge.
//   Clearing the last bit -> FIN, Valid<=0, Busy<=0.
//   EN=1 in SCAN: freeze; Valid drops to 0 combinationally-registered on next edge; pend is not modified.
//   Resumes with the same Y when EN returns to 0.
//   Start ignored in SCAN and FIN; In changes after latch have no effect.
//  FIN: Done=1 for exactly one cycle, then -> IDLE. None remains at its value.
//  Ready with Valid=0 is ignored. Ready held high: one index per cycle, so K set bits -> K Valid cycles.
//  N not a power of 2: Y never exceeds N-1.
//  RST_n low mid-scan: immediate return to reset values; no Done pulse.
// CONFIGURATION
//  PRI_ENC_LSB_FIRST_EN defined: scan order is lowest index first (bit 0 highest priority).
//  PRI_ENC_LSB_FIRST_EN undefined (default): highest index first, matching the 8-to-3 encoder.
//  Only the priority finder changes; FSM, handshake and timing are identical.
// STRUCTURE
//  pri_enc_pkg:
//   - state encoding localparams (IDLE/SCAN/FIN)
//   - clog2 function, shared by N->W users
//  Sub-module pri_enc_find (combinational): N-bit vector -> W-bit index + found flag.
//   - honours PRI_ENC_LSB_FIRST_EN
//  Top holds pend register, FSM and output registers.
// TESTING (N=8)
//  1. Reset mid-scan: RST_n=0 with pend=8'h81 in SCAN -> all outputs 0 that cycle; no Done.
//  2. Start, EN=0, In=8'b1010_0100, Ready=1 -> Y = 7, 5, 2 on consecutive Valid cycles.
//     Then Done for 1 cycle; Busy high 3 cycles.
//  3. Start, In=8'h00 -> Done 1 cycle after Start, None=1, Valid never asserted.
//  4. In=8'h0C, Ready=0 for 4 cycles -> Y=3, Valid=1 held stable; Ready=1 -> Y=2, then Done.
//  5. In=8'hFF, EN=1 after 2 accepts -> Valid=0 and pend=8'h3F held; EN=0 -> Y=5 resumes.
//  6. Build with PRI_ENC_LSB_FIRST_EN, In=8'b1010_0100 -> Y = 2, 5, 7; Start during SCAN ignored.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
// Holds the FSM state encoding and a clog2 helper used to derive the index width from N.
// Build option: PRI_ENC_LSB_FIRST_EN selects lowest-index-first priority (in pri_enc_find).
package pri_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Smallest r with 2**r >= n (n >= 2 gives r >= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pri_enc_find.sv
// Combinational priority finder: N-bit vector -> index of the winning set bit + found flag.
// Latency: 0 cycles (pure combinational); no backpressure.
// Ports: vec (in, N), idx (out, W), found (out, 1). Build option PRI_ENC_LSB_FIRST_EN:
// bit 0 wins; default: bit N-1 wins.
module pri_enc_find
    import pri_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // The last set bit visited in the loop wins, so the loop direction sets the priority.
    always_comb begin
        idx   = '0;
        found = 1'b0;
`ifdef PRI_ENC_LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/pri_enc_seq.sv
// Sequential priority encoder: latches In on Start and emits each set-bit index in priority order.
// Latency: first index valid 1 cycle after Start; one index per accepted Valid&Ready cycle.
// Backpressure: Ready=0 or EN=1 holds the current index; EN=1 also drops Valid until EN returns to 0.
// Ports: CLK, RST_n (async active-low), EN (active-low run enable), Start, In[N], Ready ->
// Y[W], Valid, Busy, None, Done. Build option PRI_ENC_LSB_FIRST_EN flips the priority order.
module pri_enc_seq
    import pri_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         EN,
    input  logic         Start,
    input  logic [N-1:0] In,
    input  logic         Ready,
    output logic [W-1:0] Y,
    output logic         Valid,
    output logic         Busy,
    output logic         None,
    output logic         Done
);

    localparam logic [N-1:0] ONE = {{(N - 1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] y_q, y_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         none_q, none_d;
    logic         done_q, done_d;
    logic         found_d;
    logic         start_go;
    logic         accept;

    assign start_go = Start & ~EN;
    assign accept   = valid_q & Ready & ~EN;

    // Pending-request register: loaded on Start, loses the presented bit on each accept.
    always_comb begin
        pend_d = pend_q;
        unique case (state_q)
            ST_IDLE: if (start_go) pend_d = In;
            ST_SCAN: if (accept)   pend_d = pend_q & ~(ONE << y_q);
            default: pend_d = pend_q;
        endcase
    end

    // Y is registered from the next pend value, so the next index appears on the accept edge.
    pri_enc_find #(
        .N (N),
        .W (W)
    ) u_find (
        .vec   (pend_d),
        .idx   (y_d),
        .found (found_d)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        none_d  = none_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    none_d = 1'b0;
                    if (found_d) begin
                        state_d = ST_SCAN;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_FIN;
                        none_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (EN) begin
                    // Frozen: hide Y but keep pend so the same index resumes.
                    valid_d = 1'b0;
                end else if (accept && !found_d) begin
                    state_d = ST_FIN;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            none_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            none_q  <= none_d;
            done_q  <= done_d;
        end
    end

    assign Y     = y_q;
    assign Valid = valid_q;
    assign Busy  = busy_q;
    assign None  = none_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_pri_enc_seq.sv
// Scoreboard bench for pri_enc_seq (N=8): stimulus pushes the expected index list per scan,
// a negedge monitor pops and compares on every Valid&Ready&EN=0 handshake.
module tb_pri_enc_seq;

    localparam int N = 8;
    localparam int W = 3;

    logic         CLK = 1'b0;
    logic         RST_n = 1'b1;
    logic         EN = 1'b0;
    logic         Start = 1'b0;
    logic [N-1:0] In = '0;
    logic         Ready = 1'b0;
    logic [W-1:0] Y;
    logic         Valid, Busy, None, Done;

    pri_enc_seq #(.N(N)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .EN    (EN),
        .Start (Start),
        .In    (In),
        .Ready (Ready),
        .Y     (Y),
        .Valid (Valid),
        .Busy  (Busy),
        .None  (None),
        .Done  (Done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;
    int exp_q[$];
    int done_cnt = 0, busy_cnt = 0, valid_cnt = 0, hs_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: the list of set-bit indices in service order.
    function automatic void model_push(input logic [N-1:0] v);
`ifdef PRI_ENC_LSB_FIRST_EN
        for (int i = 0; i < N; i++) if (v[i]) exp_q.push_back(i);
`else
        for (int i = N - 1; i >= 0; i--) if (v[i]) exp_q.push_back(i);
`endif
    endfunction

    function automatic logic [N-1:0] model_pend();
        logic [N-1:0] r;
        r = '0;
        foreach (exp_q[i]) r[exp_q[i]] = 1'b1;
        return r;
    endfunction

    // Monitor: inputs are stable at the negedge and are what the next rising edge uses.
    always @(negedge CLK) begin
        if (RST_n) begin
            if (Valid) valid_cnt++;
            if (Busy)  busy_cnt++;
            if (Done)  done_cnt++;
            if (Valid && Ready && !EN) begin
                hs_cnt++;
                check("y_order", int'(Y), (exp_q.size() > 0) ? exp_q.pop_front() : -1);
            end
        end
    end

    task automatic do_start(input logic [N-1:0] v);
        @(posedge CLK); #1;
        Start = 1'b1; In = v; EN = 1'b0;
        model_push(v);
        @(posedge CLK); #1;
        Start = 1'b0;
        In = N'($urandom);   // must not matter once latched
    endtask

    task automatic finish_scan(input logic [N-1:0] v, input int rdy_pct, input int en_pct,
                               input bit rnd_start, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 300) begin
            Ready = ($urandom_range(99) < rdy_pct);
            EN    = ($urandom_range(99) < en_pct);
            if (rnd_start) begin
                Start = 1'($urandom_range(1));
                In    = N'($urandom);
            end
            @(negedge CLK);
            if (Done) seen = 1'b1;
            else begin
                @(posedge CLK); #1;
                cyc++;
            end
        end
        Start = 1'b0; EN = 1'b0; Ready = 1'b0;
        check("done_seen", int'(seen), 1);
        @(negedge CLK);
        check("done_one_cycle", int'(Done), 0);
        check("idle_valid", int'(Valid), 0);
        check("idle_busy", int'(Busy), 0);
        check("scan_drained", exp_q.size(), 0);
        check("none_flag", int'(None), int'(v == '0));
    endtask

    initial begin
        int cyc, h0, b0, v0, d0;
        logic [N-1:0] v;

        // Reset values
        #2 RST_n = 1'b0;
        #1;
        check("rst_valid", int'(Valid), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_none", int'(None), 0);
        check("rst_done", int'(Done), 0);
        check("rst_y", int'(Y), 0);
        @(negedge CLK); #1 RST_n = 1'b1;

        // Reset mid-scan with 8'h81 pending
        do_start(8'h81);
        Ready = 1'b0;
        @(negedge CLK);
        check("mid_valid_before_rst", int'(Valid), 1);
        #2 RST_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", int'(Valid), 0);
        check("mid_rst_busy", int'(Busy), 0);
        check("mid_rst_y", int'(Y), 0);
        check("mid_rst_done", int'(Done), 0);
        check("mid_rst_pend", int'(dut.pend_q), 0);
        d0 = done_cnt;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1 RST_n = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("mid_rst_no_done", done_cnt - d0, 0);

        // 1010_0100 with Ready held high: three indices on consecutive cycles
        v = 8'b1010_0100;
        h0 = hs_cnt; b0 = busy_cnt; v0 = valid_cnt;
        do_start(v);
        finish_scan(v, 100, 0, 1'b0, cyc);
        check("t2_cycles", cyc, 3);
        check("t2_busy_cycles", busy_cnt - b0, 3);
        check("t2_valid_cycles", valid_cnt - v0, 3);
        check("t2_handshakes", hs_cnt - h0, 3);

        // All-zero vector: Done right after Start, never Valid
        v0 = valid_cnt;
        do_start(8'h00);
        finish_scan(8'h00, 100, 0, 1'b0, cyc);
        check("t3_done_latency", cyc, 0);
        check("t3_valid_cycles", valid_cnt - v0, 0);

        // 8'h0C with Ready low for 4 cycles: Y held stable
        do_start(8'h0C);
        Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("t4_stall_valid", int'(Valid), 1);
            check("t4_stall_y", int'(Y), exp_q[0]);
            @(posedge CLK); #1;
        end
        finish_scan(8'h0C, 100, 0, 1'b0, cyc);
        check("t4_cycles", cyc, 2);

        // 8'hFF, freeze after two accepts
        do_start(8'hFF);
        Ready = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            check("t5_frozen_valid", int'(Valid), 0);
            check("t5_frozen_pend", int'(dut.pend_q), int'(model_pend()));
            check("t5_frozen_y", int'(Y), exp_q[0]);
            check("t5_remaining", exp_q.size(), 6);
        end
        finish_scan(8'hFF, 100, 0, 1'b0, cyc);

        // Start/In toggled throughout a scan must be ignored
        v = 8'b1010_0100;
        h0 = hs_cnt;
        do_start(v);
        finish_scan(v, 100, 0, 1'b1, cyc);
        check("t6_handshakes", hs_cnt - h0, 3);

        // Randomized scans with random Ready/EN and spurious Start
        for (int r = 0; r < 40; r++) begin
            v = N'($urandom);
            if ($urandom_range(5) == 0) v = '0;
            h0 = hs_cnt;
            do_start(v);
            finish_scan(v, int'($urandom_range(100, 30)), int'($urandom_range(40)), 1'b1, cyc);
            check("rnd_handshakes", hs_cnt - h0, $countones(v));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
